// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer:
//   - FSM state encoding (IDLE/RUN/HALT/FAULT, also exported on the debug port)
//   - instruction width and PC increment
//   - the {pc, inst} entry carried through the fetch buffer
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          INST_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Circular fetch buffer with wrap-around read/write pointers and an occupancy
// count. FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap
// naturally.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   push        write push_data at the tail (accepted when not full, or when
//               full and popping in the same cycle)
//   push_data   WIDTH-bit entry to enqueue
//   pop         drop the head entry (ignored when empty)
//   flush       discard all entries; overrides push and pop
//   full/empty  occupancy flags
//   head_data   entry at the head (undefined when empty)
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int WIDTH      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    // A full buffer can take a new entry only in the cycle its head leaves.
    assign do_push = push & (~full | do_pop);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and empty/full come from the reset count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller. Owns the PC, drives the combinational
// instruction memory one word per cycle, buffers {pc, inst} in fetch_fifo and
// presents the head to decode over valid/ready.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 pulse: IDLE->RUN, HALT->RUN
//   halt_req              RUN->HALT after the current cycle
//   redirect_valid/_pc    new PC from execute (RUN/HALT only)
//   im_en, im_addr        instruction-memory enable and word index
//   im_inst               instruction-memory read data (same cycle)
//   out_valid/ready       decode handshake on the buffer head
//   out_inst, out_pc      head instruction and its byte PC
//   state                 FSM state (debug)
//   fault                 sticky fetch fault, cleared only by reset
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 32,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_en,
    output logic [31:0] im_addr,
    input  logic [31:0] im_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [1:0]  state,
    output logic        fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  im_addr_q;

    logic         fifo_full, fifo_empty;
    logic         fifo_push, fifo_pop, fifo_flush;
    logic         head_pop, pc_oob;
    fetch_entry_t push_entry, head_entry;

    assign head_pop   = ~fifo_empty & out_ready;
    assign pc_oob     = ({2'b00, pc_q[31:2]} >= 32'(IMEM_DEPTH));
    assign push_entry = '{pc: pc_q, inst: im_inst};

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        im_en      = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        fifo_pop   = head_pop;

        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end

            ST_RUN, ST_HALT: begin
                if (redirect_valid) begin
                    // Redirect outranks halt_req and start. A misaligned
                    // target faults without touching pc or the buffer.
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d = ST_FAULT;
                    end else begin
                        fifo_flush = 1'b1;
                        fifo_pop   = 1'b0;
                        pc_d       = redirect_pc;
                    end
                end else if (state_q == ST_RUN) begin
                    if (halt_req) state_d = ST_HALT;
                    // Room exists if not full, or if the head leaves now.
                    if (!fifo_full || head_pop) begin
                        if (pc_oob) begin
                            state_d = ST_FAULT;
                        end else begin
                            im_en     = 1'b1;
                            fifo_push = 1'b1;
                            pc_d      = pc_q + PC_INC;
                        end
                    end
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end

            ST_FAULT: begin
                // Sticky until reset; the buffer keeps draining.
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            im_addr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (im_en) im_addr_q <= {2'b00, pc_q[31:2]};
        end
    end

    // Address is live while fetching and otherwise holds the last word index.
    assign im_addr = im_en ? {2'b00, pc_q[31:2]} : im_addr_q;

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      ($bits(fetch_entry_t))
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_data  (push_entry),
        .pop        (fifo_pop),
        .flush      (fifo_flush),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_data  (head_entry)
    );

    // Head fields read as zero when nothing is buffered.
    assign out_valid = ~fifo_empty;
    assign out_inst  = fifo_empty ? '0 : head_entry.inst;
    assign out_pc    = fifo_empty ? '0 : head_entry.pc;
    assign state     = state_q;
    assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Random stimulus against a queue-based reference model of the fetch
// sequencer, plus a short directed run of a second instance started from
// RESET_PC = 0x78 near the top of instruction memory.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int          DEPTH   = 32;
    localparam int          FD      = 2;
    localparam logic [31:0] INST_BASE = 32'hA000_0000;

    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt_req, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic        im_en, out_valid, fault;
    logic [31:0] im_addr, im_inst, out_inst, out_pc;
    logic [1:0]  state;

    logic        start_b;
    logic        im_en_b, out_valid_b, fault_b;
    logic [31:0] im_addr_b, im_inst_b, out_inst_b, out_pc_b;
    logic [1:0]  state_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instruction memory: word k holds INST_BASE + k.
    assign im_inst   = (im_addr   < 32'(DEPTH)) ? INST_BASE + im_addr   : 32'hBAD0_0000;
    assign im_inst_b = (im_addr_b < 32'(DEPTH)) ? INST_BASE + im_addr_b : 32'hBAD0_0000;

    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH), .FIFO_DEPTH(FD)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .im_en(im_en), .im_addr(im_addr), .im_inst(im_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .state(state), .fault(fault)
    );

    fetch_sequencer #(.RESET_PC(32'h78), .IMEM_DEPTH(DEPTH), .FIFO_DEPTH(FD)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .halt_req(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .im_en(im_en_b), .im_addr(im_addr_b), .im_inst(im_inst_b),
        .out_valid(out_valid_b), .out_ready(1'b1),
        .out_inst(out_inst_b), .out_pc(out_pc_b), .state(state_b), .fault(fault_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural pc, state, last word address and a queue
    // of {pc, inst} entries that decode has not yet taken.
    int          m_st;
    logic [31:0] m_pc, m_addr;
    logic [63:0] m_q[$];

    task automatic model_reset();
        m_st   = M_IDLE;
        m_pc   = 32'h0;
        m_addr = 32'h0;
        m_q.delete();
    endtask

    // Called just after inputs are driven: compare outputs, then advance the
    // model across the next rising edge.
    task automatic step();
        bit          full, hp, pop, push, flush, en;
        int          nst;
        logic [31:0] npc;

        #1;
        full  = (m_q.size() == FD);
        hp    = (m_q.size() != 0) && out_ready;
        pop   = hp;
        push  = 1'b0;
        flush = 1'b0;
        en    = 1'b0;
        nst   = m_st;
        npc   = m_pc;

        if ((m_st == M_RUN || m_st == M_HALT) && redirect_valid) begin
            if (redirect_pc % 4 != 0) begin
                nst = M_FAULT;
            end else begin
                flush = 1'b1;
                pop   = 1'b0;
                npc   = redirect_pc;
            end
        end else if (m_st == M_RUN) begin
            if (halt_req) nst = M_HALT;
            if (!full || hp) begin
                if (m_pc / 4 >= DEPTH) nst = M_FAULT;
                else begin
                    en   = 1'b1;
                    push = 1'b1;
                    npc  = m_pc + 4;
                end
            end
        end else if ((m_st == M_IDLE || m_st == M_HALT) && start) begin
            nst = M_RUN;
        end

        check("out_valid", out_valid, m_q.size() != 0);
        check("out_pc",    out_pc,    (m_q.size() != 0) ? m_q[0][63:32] : 32'h0);
        check("out_inst",  out_inst,  (m_q.size() != 0) ? m_q[0][31:0]  : 32'h0);
        check("im_en",     im_en,     en);
        check("im_addr",   im_addr,   en ? m_pc / 4 : m_addr);
        check("state",     state,     32'(m_st));
        check("fault",     fault,     m_st == M_FAULT);

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (flush) m_q.delete();
            else begin
                if (pop)  void'(m_q.pop_front());
                if (push) m_q.push_back({m_pc, INST_BASE + m_pc / 4});
            end
            if (en) m_addr = m_pc / 4;
            m_st = nst;
            m_pc = npc;
        end
    endtask

    task automatic drive_idle();
        start          = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        start_b = 1'b0;
        drive_idle();
        model_reset();

        // Reset for two cycles, then start with ready held high.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            step();
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_idle();
            step();
        end

        // Randomised traffic with occasional mid-run resets.
        for (int i = 0; i < 4000; i++) begin
            int r;
            @(negedge clk);
            rst_n          = ($urandom_range(0, 59) != 0);
            start          = ($urandom_range(0, 9) == 0);
            halt_req       = ($urandom_range(0, 19) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            r              = $urandom_range(0, 99);
            redirect_pc    = 32'($urandom_range(0, 36)) * 4;
            if (r < 4) redirect_pc = redirect_pc | 32'($urandom_range(1, 3));
            step();
        end

        // Second instance: RESET_PC=0x78 fetches words 30 and 31, then the
        // attempt at pc 0x80 faults without an enqueue.
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("b_reset_state", state_b, 32'd0);
        check("b_reset_valid", out_valid_b, 1'b0);
        check("b_reset_addr",  im_addr_b, 32'h0);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        #1;
        check("b_run_state",  state_b,   32'd1);
        check("b_fetch30_en", im_en_b,   1'b1);
        check("b_fetch30",    im_addr_b, 32'd30);
        check("b_first_vld",  out_valid_b, 1'b0);
        @(negedge clk);
        #1;
        check("b_out_pc78",   out_pc_b,   32'h78);
        check("b_out_inst30", out_inst_b, INST_BASE + 32'd30);
        check("b_fetch31",    im_addr_b,  32'd31);
        @(negedge clk);
        #1;
        check("b_out_pc7c",   out_pc_b,   32'h7C);
        check("b_out_inst31", out_inst_b, INST_BASE + 32'd31);
        check("b_oob_en",     im_en_b,    1'b0);
        check("b_oob_addr",   im_addr_b,  32'd31);
        check("b_pre_fault",  fault_b,    1'b0);
        @(negedge clk);
        #1;
        check("b_fault",       fault_b,     1'b1);
        check("b_fault_state", state_b,     32'd3);
        check("b_drained",     out_valid_b, 1'b0);
        check("b_fault_en",    im_en_b,     1'b0);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        #1;
        check("b_fault_sticky", state_b, 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("b_fault_clear", fault_b, 1'b0);
        check("b_idle_again",  state_b, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
